// File: rtl/param_tfhe_pkg.sv
// Shared TFHE parameters plus the modulus-switch output types that blind rotation consumes.
package param_tfhe_pkg;

  localparam int LWE_COEF_W = 12;
  localparam int LWE_K      = 4;
  localparam int LWE_K_P1_W = $clog2(LWE_K + 1);
  localparam int MOD_Q_W    = 64;
  localparam int PID_W      = 8;

  localparam logic [LWE_K_P1_W-1:0] LWE_K_IDX = LWE_K_P1_W'(LWE_K);

  typedef logic [LWE_COEF_W-1:0] ms_coef_t;
  typedef logic [LWE_K_P1_W-1:0] ms_idx_t;

  typedef struct packed {
    ms_coef_t          coef;
    ms_idx_t           idx;
    logic [PID_W-1:0]  pid;
    logic              body;
  } ms_out_t;

endpackage

// File: rtl/pbs_ms_pipe_reg.sv
// Generic valid/ready register stage carrying one ms_out_t; holds its contents while stalled.
module pbs_ms_pipe_reg
  import param_tfhe_pkg::*;
(
  input  logic    clk,
  input  logic    a_rst_n,
  input  logic    in_vld,
  input  ms_out_t in_data,
  output logic    in_rdy,
  output logic    out_vld,
  output ms_out_t out_data,
  input  logic    out_rdy
);

  logic    vld_q;
  ms_out_t data_q;

  assign in_rdy   = !vld_q || out_rdy;
  assign out_vld  = vld_q;
  assign out_data = data_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_rdy) begin
      vld_q <= in_vld;
      if (in_vld) data_q <= in_data;
    end
  end

endmodule

// File: rtl/pbs_mod_switch.sv
// Modulus switch of LWE coefficients into [0, 2N) ahead of blind rotation.
// Define PBS_MOD_SWITCH_ROUND_EN for round-to-nearest; otherwise the coefficient is truncated.
module pbs_mod_switch
  import param_tfhe_pkg::*;
(
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic [MOD_Q_W-1:0]    in_coef,
  input  logic [PID_W-1:0]      in_pid,
  input  logic                  in_last,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [LWE_COEF_W-1:0] out_coef,
  output logic [LWE_K_P1_W-1:0] out_idx,
  output logic [PID_W-1:0]      out_pid,
  output logic                  out_body,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  err_last
);

  if (MOD_Q_W < LWE_COEF_W + 1) begin : g_width_chk
    $error("pbs_mod_switch: MOD_Q_W must be at least LWE_COEF_W+1");
  end

  logic     s0_vld_q;
  ms_out_t  s0_q;
  ms_out_t  s0_d;
  ms_idx_t  idx_q;
  ms_idx_t  idx_d;
  logic     err_q;
  logic     err_d;
  logic     s0_adv;
  logic     s1_adv;
  logic     hs;
  logic     is_body;
  ms_coef_t coef_d;
  logic     unused_bits;
  ms_out_t  s1_data;

`ifdef PBS_MOD_SWITCH_ROUND_EN
  logic [LWE_COEF_W:0]   r;
  logic [LWE_COEF_W+1:0] r_sum;

  // One spare bit below the output LSB plus a carry bit: adding half an LSB cannot overflow.
  assign r           = in_coef[MOD_Q_W-1 -: LWE_COEF_W+1];
  assign r_sum       = {1'b0, r} + (LWE_COEF_W+2)'(1);
  assign coef_d      = r_sum[LWE_COEF_W:1];
  assign unused_bits = ^{r_sum[LWE_COEF_W+1], r_sum[0], in_coef[MOD_Q_W-LWE_COEF_W-2:0]};
`else
  assign coef_d      = in_coef[MOD_Q_W-1 -: LWE_COEF_W];
  assign unused_bits = ^in_coef[MOD_Q_W-LWE_COEF_W-1:0];
`endif

  assign s0_adv  = !s0_vld_q || s1_adv;
  assign in_rdy  = s0_adv;
  assign hs      = in_vld && s0_adv;
  assign is_body = (idx_q == LWE_K_IDX);

  // The counter alone decides framing; in_last is only cross-checked.
  always_comb begin
    idx_d = idx_q;
    err_d = 1'b0;
    s0_d  = s0_q;
    if (hs) begin
      idx_d     = is_body ? '0 : idx_q + ms_idx_t'(1);
      err_d     = (in_last != is_body);
      s0_d.coef = coef_d;
      s0_d.idx  = idx_q;
      s0_d.pid  = in_pid;
      s0_d.body = is_body;
    end
  end

  // S0: computed coefficient register
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      s0_vld_q <= 1'b0;
      s0_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      s0_q  <= s0_d;
      if (s0_adv) s0_vld_q <= in_vld;
    end
  end

  // S1: output register
  pbs_ms_pipe_reg u_s1 (
    .clk      (clk),
    .a_rst_n  (a_rst_n),
    .in_vld   (s0_vld_q),
    .in_data  (s0_q),
    .in_rdy   (s1_adv),
    .out_vld  (out_vld),
    .out_data (s1_data),
    .out_rdy  (out_rdy)
  );

  assign out_coef = s1_data.coef;
  assign out_idx  = s1_data.idx;
  assign out_pid  = s1_data.pid;
  assign out_body = s1_data.body;
  assign err_last = err_q;

endmodule

// File: doc/pbs_mod_switch.md
# pbs_mod_switch

Modulus-switch stage directly upstream of blind rotation. It consumes a stream of LWE coefficients of `MOD_Q_W` bits, `LWE_K` masks followed by one body per ciphertext. It rescales each coefficient to the rotation domain [0, 2N), `LWE_COEF_W` bits, and emits it with its coefficient index and a body flag. The blind-rotation controller and the accumulator rotation logic use this output directly.

## Interface
Parameters come from `param_tfhe_pkg`; there are no module parameters of its own.
- `PID_W`, 8, width of the ciphertext identifier carried alongside each coefficient.

Ports:
- `clk`  in  1  single clock domain.
- `a_rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_coef`  in  MOD_Q_W  LWE coefficient, unsigned mod 2^MOD_Q_W.
- `in_pid`  in  PID_W  ciphertext id; sampled on every input handshake.
- `in_last`  in  1  upstream marks the body coefficient.
- `in_vld`  in  1  input valid.
- `in_rdy`  out  1  input ready.
- `out_coef`  out  LWE_COEF_W  switched coefficient in [0, 2N).
- `out_idx`  out  LWE_K_P1_W  coefficient index 0..LWE_K; LWE_K is the body.
- `out_pid`  out  PID_W  id carried through.
- `out_body`  out  1  set when out_idx == LWE_K.
- `out_vld`  out  1  output valid.
- `out_rdy`  in  1  downstream ready.
- `err_last`  out  1  one-cycle pulse on framing mismatch.

## Operation
- Coefficient counter `idx`, LWE_K_P1_W bits, reset 0.
  - Increments on each input handshake (in_vld & in_rdy).
  - Wraps to 0 after the handshake at idx == LWE_K.
- Arithmetic, in S0:
  - r = in_coef[MOD_Q_W-1 -: LWE_COEF_W+1].
  - out_coef = ((r + 1) >> 1) mod 2^LWE_COEF_W.
  - This is round-to-nearest of in_coef·2N/2^MOD_Q_W. The value 2N wraps to 0.
  - The adder is LWE_COEF_W+2 bits wide, so it never saturates.
- Elaboration fails via `$error` if MOD_Q_W < LWE_COEF_W+1.
- Framing:
  - Body is defined by the counter (idx == LWE_K), never by in_last.
  - If in_last != (idx == LWE_K) on a handshake, err_last pulses in the following cycle.
  - Data still flows and the counter is not resynchronised.
- Pipeline is two registered stages: S0 (computed value), then S1 (output register).
  - s1_adv = !s1_vld | out_rdy.
  - s0_adv = !s0_vld | s1_adv.
  - in_rdy = s0_adv, combinational from out_rdy.
- No bubbles at full throughput. With out_rdy held high, one coefficient per cycle.
- out_* holds stable while out_vld & !out_rdy.

## Timing
- Latency: input handshake at cycle t gives out_vld at t+2 if no backpressure.
- Reset values: out_vld=0, err_last=0, out_coef=0, out_idx=0, out_pid=0, out_body=0. in_rdy is 1 during and after reset.
- Reset mid-ciphertext: the pipeline is emptied and idx returns to 0. The next input is treated as mask 0.
- Simultaneous events, with S1 full, out_rdy=1 and S0 full: S1 takes S0 and S0 takes the new input in the same cycle.
- Sustained out_rdy=0:
  - Two coefficients are held (S0, S1), then in_rdy=0.
  - Neither is lost or duplicated when out_rdy returns.
- Counter wrap and the next ciphertext's mask 0 may share consecutive cycles with no gap.

## Configuration
- `PBS_MOD_SWITCH_ROUND_EN`, defined: round-to-nearest as above.
- Undefined: truncation.
  - out_coef = in_coef[MOD_Q_W-1 -: LWE_COEF_W].
  - The adder and the extra bit are removed.
  - Latency and handshake are unchanged.

## Structure
- Shared constants come from `param_tfhe_pkg`: LWE_COEF_W, LWE_K, LWE_K_P1_W, MOD_Q_W.
- Add to the shared package: typedef `ms_coef_t` (logic [LWE_COEF_W-1:0]) and struct `ms_out_t` {coef, idx, pid, body}. Blind rotation consumes these.
- One natural sub-module: `pbs_ms_pipe_reg`, a generic valid/ready register stage on `ms_out_t`, instantiated for S1. S0 is inline with the arithmetic.

## Test plan
Configuration for all scenarios: N=2048 (LWE_COEF_W=12), MOD_Q_W=64, LWE_K=4, out_rdy=1, rounding on.
- in_coef=2^63 → out_coef=2048, out_idx=0, out_vld two cycles after the handshake.
- in_coef=2^64-1 → out_coef=0 (wrap). in_coef=2^51 → out_coef=1 with rounding, 0 without the macro.
- 10 back-to-back coefficients, in_last on the 5th and 10th → out_idx sequence 0,1,2,3,4,0,1,2,3,4, out_body on idx 4, err_last never set.
- in_last on the 3rd coefficient → err_last pulses once, one cycle after that handshake. out_idx sequence is unchanged.
- out_rdy=0 for 6 cycles while streaming → in_rdy drops after two accepted coefficients. On release, outputs appear in order with no loss or duplication, and out_* stays stable while stalled.
- a_rst_n asserted after idx=2 → all outputs go to reset values. The next coefficient is emitted with out_idx=0.
